// File: rtl/sync_up_counter_pkg.sv
// ============================================================================
// Module   : sync_up_counter_pkg
// Brief    : Shared state type and default widths for the up/down counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_up_counter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_WRAPW = 8;

  typedef enum logic [0:0] {
    COUNT = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sync_up_counter_sat_inc.sv
// ============================================================================
// Module   : sync_up_counter_sat_inc
// Brief    : Saturating incrementer; sticks at all-ones instead of rolling over.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_up_counter_sat_inc #(
  parameter int W = 8
) (
  input  logic [W-1:0] in_val,
  input  logic         inc,
  output logic [W-1:0] out_val
);

  always_comb begin
    out_val = in_val;
    if (inc && (in_val != {W{1'b1}})) begin
      out_val = in_val + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sync_up_counter.sv
// ============================================================================
// Module   : sync_up_counter
// Brief    : Up counter to a programmable MAX with free-run/one-shot modes,
//            load, clear, terminal-count strobe and saturating wrap count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_up_counter
  import sync_up_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX   = 2**WIDTH - 1,
  parameter int WRAPW = DEF_WRAPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             done,
  output logic [WRAPW-1:0] wraps
);

  localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [WRAPW-1:0]   wraps_q, wraps_d;
  logic [WRAPW-1:0]   wraps_inc;
  logic               wrap_evt;
  logic               at_max;

  assign at_max = (cnt_q == MAX_V);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clr > load > en
  always_comb begin
    state_d = state_q;
    if (clr || load) begin
      state_d = COUNT;
    end else if (en && (state_q == COUNT) && at_max && oneshot) begin
      state_d = HOLD;
    end
  end

  // Output logic; tc flags the cycle whose edge will wrap or finish
  always_comb begin
    tc    = en & at_max & (state_q == COUNT) & ~clr & ~load;
    out   = cnt_q;
    done  = done_q;
    wraps = wraps_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    done_d   = done_q;
    wrap_evt = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (load) begin
      cnt_d  = (load_val > MAX_V) ? MAX_V : load_val;
      done_d = 1'b0;
    end else if (en && (state_q == COUNT)) begin
      if (!at_max) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else if (!oneshot) begin
        cnt_d    = '0;
        wrap_evt = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end
  end

  sync_up_counter_sat_inc #(
    .W (WRAPW)
  ) u_wrap_inc (
    .in_val  (wraps_q),
    .inc     (wrap_evt),
    .out_val (wraps_inc)
  );

  always_comb begin
    wraps_d = clr ? '0 : wraps_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      done_q  <= 1'b0;
      wraps_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      wraps_q <= wraps_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_up_counter.sv
// ============================================================================
// Module   : tb_sync_up_counter
// Brief    : Scoreboard bench for sync_up_counter across three configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_up_counter;

  typedef struct {
    int         id;
    logic [3:0] out;
    logic       tc;
    logic       done;
    logic [7:0] wraps;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en_r      [3];
  logic       clr_r     [3];
  logic       load_r    [3];
  logic [3:0] load_val_r[3];
  logic       oneshot_r [3];

  logic [3:0] out0, out1, out2;
  logic       tc0, tc1, tc2;
  logic       done0, done1, done2;
  logic [7:0] wraps0, wraps1;
  logic [1:0] wraps2;

  exp_t q[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  sync_up_counter #(.WIDTH(4), .MAX(15), .WRAPW(8)) u_dut0 (
    .clk(clk), .rst(rst), .en(en_r[0]), .clr(clr_r[0]), .load(load_r[0]),
    .load_val(load_val_r[0]), .oneshot(oneshot_r[0]),
    .out(out0), .tc(tc0), .done(done0), .wraps(wraps0));

  sync_up_counter #(.WIDTH(4), .MAX(9), .WRAPW(8)) u_dut1 (
    .clk(clk), .rst(rst), .en(en_r[1]), .clr(clr_r[1]), .load(load_r[1]),
    .load_val(load_val_r[1]), .oneshot(oneshot_r[1]),
    .out(out1), .tc(tc1), .done(done1), .wraps(wraps1));

  sync_up_counter #(.WIDTH(4), .MAX(1), .WRAPW(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en_r[2]), .clr(clr_r[2]), .load(load_r[2]),
    .load_val(load_val_r[2]), .oneshot(oneshot_r[2]),
    .out(out2), .tc(tc2), .done(done2), .wraps(wraps2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: drains every expectation queued for the current cycle
  always begin
    exp_t       e;
    logic [3:0] a_out;
    logic       a_tc, a_done;
    logic [7:0] a_wr;
    @(negedge clk or chk_ev);
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.id)
        0:       begin a_out = out0; a_tc = tc0; a_done = done0; a_wr = wraps0; end
        1:       begin a_out = out1; a_tc = tc1; a_done = done1; a_wr = wraps1; end
        default: begin a_out = out2; a_tc = tc2; a_done = done2; a_wr = {6'b0, wraps2}; end
      endcase
      n_cmp++;
      if (a_out !== e.out || a_tc !== e.tc || a_done !== e.done || a_wr !== e.wraps) begin
        n_bad++;
        $display("FAIL %s (dut%0d): got out=%0d tc=%b done=%b wraps=%0d, want out=%0d tc=%b done=%b wraps=%0d",
                 e.name, e.id, a_out, a_tc, a_done, a_wr, e.out, e.tc, e.done, e.wraps);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pkt(input int id, input logic [3:0] eo, input logic et,
                            input logic ed, input logic [7:0] ew, input string nm);
    exp_t e;
    e.id = id; e.out = eo; e.tc = et; e.done = ed; e.wraps = ew; e.name = nm;
    q.push_back(e);
  endtask

  // Apply inputs to one instance (others idle) and queue this cycle's expectation
  task automatic drive(input int id, input logic en, input logic clr, input logic load,
                       input logic [3:0] lv, input logic os,
                       input logic [3:0] eo, input logic et, input logic ed,
                       input logic [7:0] ew, input string nm);
    for (int k = 0; k < 3; k++) begin
      en_r[k] = 1'b0; clr_r[k] = 1'b0; load_r[k] = 1'b0;
    end
    en_r[id] = en; clr_r[id] = clr; load_r[id] = load;
    load_val_r[id] = lv; oneshot_r[id] = os;
    expect_pkt(id, eo, et, ed, ew, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      en_r[k] = 1'b0; clr_r[k] = 1'b0; load_r[k] = 1'b0;
      load_val_r[k] = 4'd0; oneshot_r[k] = 1'b0;
    end

    // Reset state
    tick(); tick();
    expect_pkt(0, 4'd0, 1'b0, 1'b0, 8'd0, "reset_dut0");
    expect_pkt(1, 4'd0, 1'b0, 1'b0, 8'd0, "reset_dut1");
    expect_pkt(2, 4'd0, 1'b0, 1'b0, 8'd0, "reset_dut2");
    rst = 1'b0;

    // Count to 9, then assert rst between edges
    for (int k = 0; k < 10; k++) begin
      tick();
      drive(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'(k), 1'b0, 1'b0, 8'd0, "count_pre_rst");
    end
    #6;
    rst = 1'b1;
    #1;
    expect_pkt(0, 4'd0, 1'b0, 1'b0, 8'd0, "async_rst");
    -> chk_ev;
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, "post_rst_0");
    for (int k = 1; k < 5; k++) begin
      tick();
      drive(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'(k), 1'b0, 1'b0, 8'd0, "post_rst_cnt");
    end
    tick();
    drive(0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 1'b0, 1'b0, 8'd0, "clr_before_run");

    // Free-run wrap: 0..15,0..15,0
    for (int i = 0; i <= 32; i++) begin
      tick();
      drive(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'(i % 16), (i % 16) == 15, 1'b0,
            8'(i / 16), "free_run");
    end

    // One-shot with MAX=9
    for (int i = 0; i <= 9; i++) begin
      tick();
      drive(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'(i), i == 9, 1'b0, 8'd0, "oneshot_cnt");
    end
    tick(); drive(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b1, 8'd0, "oneshot_done");
    tick(); drive(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b0, 1'b1, 8'd0, "hold_os0");
    tick(); drive(1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 4'd9, 1'b0, 1'b1, 8'd0, "hold_still");
    tick(); drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 8'd0, "load3_exit");
    tick(); drive(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 8'd0, "idle_hold");
    tick(); drive(1, 1'b1, 1'b0, 1'b1, 4'd12, 1'b0, 4'd4, 1'b0, 1'b0, 8'd0, "count_4");
    tick(); drive(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 8'd0, "load_clamp");
    tick(); drive(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd1, "wrap9");
    tick(); drive(1, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 4'd1, 1'b0, 1'b0, 8'd1, "pre_clr_load");
    tick(); drive(1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, "clr_beats_load");
    tick(); drive(1, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 4'd9, 1'b0, 1'b0, 8'd0, "tc_masked_load");
    tick(); drive(1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd9, 1'b0, 1'b0, 8'd0, "tc_masked_clr");
    tick(); drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, "after_clr");

    // Wrap counter saturation: WRAPW=2, MAX=1
    for (int i = 0; i <= 12; i++) begin
      tick();
      drive(2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'(i % 2), (i % 2) == 1, 1'b0,
            8'((i / 2) > 3 ? 3 : (i / 2)), "saturate");
    end

    // Enable gating on dut0 (left at out=1, wraps=2)
    tick(); drive(0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 8'd2, "gate_clr");
    for (int j = 0; j < 6; j++) begin
      tick();
      drive(0, (j % 2) == 0, 1'b0, 1'b0, 4'd0, 1'b0, 4'((j + 1) / 2), 1'b0, 1'b0, 8'd0, "gate_en");
    end
    tick(); drive(0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 4'd3, 1'b0, 1'b0, 8'd0, "gate_load15");
    tick(); drive(0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b0, 1'b0, 8'd0, "tc_en0");
    tick(); drive(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0, 8'd0, "tc_en1");
    tick(); drive(0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd1, "gate_wrap");

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_up_counter.md
# sync_up_counter

Parameterised synchronous up counter: the ascending counterpart to the existing 4-bit synchronous down counter, sharing its clock/reset interface and lab test harness. Counts from 0 toward a programmable terminal value. Either wraps (free-run) or stops and holds (one-shot). Provides parallel load, synchronous clear, a terminal-count strobe for cascading, and a saturating wrap counter.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥ 2)
- MAX, 2**WIDTH-1, terminal count value (1 ≤ MAX ≤ 2**WIDTH-1)
- WRAPW, 8, width of wrap-event counter

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state immediately
- en  in  1  count enable
- clr  in  1  synchronous clear to 0
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value for load
- oneshot  in  1  0 = free-run/wrap, 1 = stop at MAX
- out  out  WIDTH  current count
- tc  out  1  terminal-count strobe (combinational)
- done  out  1  one-shot finished flag (registered)
- wraps  out  WRAPW  number of MAX→0 wraps, saturating

## Operation
- Two-state FSM: COUNT, HOLD. Reset state COUNT.
- Per-cycle priority, highest first: rst > clr > load > en > idle.
- clr: out←0, wraps←0, done←0, state←COUNT.
- load: out←min(load_val, MAX); state←COUNT; done←0; wraps unchanged.
- en in COUNT, out<MAX: out←out+1.
- en in COUNT, out==MAX, oneshot=0: out←0; wraps←wraps+1, saturating at 2**WRAPW-1.
- en in COUNT, out==MAX, oneshot=1: out stays MAX; state←HOLD; done←1.
- HOLD: en ignored, out frozen at MAX, done held 1. Exit only by clr, load or rst.
- en=0: all state holds.
- tc = en & (out==MAX) & (state==COUNT) & ~clr & ~load. It marks the cycle in which the next edge wraps or finishes, and can drive the next stage's en when cascading.
- oneshot is sampled every cycle. Changing it to 0 while in HOLD does not leave HOLD.
- Increment arithmetic is WIDTH bits. When MAX = 2**WIDTH-1 the wrap is the natural overflow, but the MAX compare is still what governs it.

## Timing
- Reset values: out=0, tc=0, done=0, wraps=0, state=COUNT. Asserting rst mid-count clears these asynchronously without waiting for clk. Release is synchronous to the next edge.
- Latency: en/clr/load act on the next rising edge. out is valid one cycle later, registered with no combinational path from inputs.
- tc is combinational from en/clr/load and registered out, with zero latency. It asserts for exactly one cycle per wrap when en is held high.
- done rises on the same edge that enters HOLD.
- wraps increments on the same edge that out goes MAX→0.
- Free-run with en held high: period = MAX+1 cycles.
- Simultaneous load & en: load wins, no increment that cycle.
- Simultaneous clr & load: clr wins.

## Structure
- Shared package (e.g. counter_pkg) holds:
  - the FSM state typedef {COUNT, HOLD}
  - default WIDTH/WRAPW constants, shared with the down counter
- No sub-module needed. The wrap counter may optionally be split into a saturating-increment sub-module, sat_inc.

## Test plan
Defaults (WIDTH=4, MAX=15) unless stated.
- **Reset:** rst=1 asserted mid-count at out=9, between clock edges → out=0, done=0, wraps=0 immediately. After release with en=1, out counts 0,1,2,… from the next edge.
- **Free-run wrap:** en=1, oneshot=0 for 32 cycles from 0 → out goes 0..15,0..15; tc high exactly while out==15 (2 pulses); wraps=2.
- **Non-power-of-two MAX:** MAX=9, en=1, oneshot=1 → out 0..9, then holds 9; done=1 on the 10th edge; further en has no effect; load_val=3 returns to COUNT with out=3, done=0.
- **Load clamp and priority:**
  - MAX=9, load=1, load_val=12, en=1 → out=9, with no increment in that cycle.
  - clr=1 with load=1 → out=0.
- **Saturation:** WRAPW=2, MAX=1, en=1 for 12 cycles → wraps stops at 3; out keeps toggling 0/1.
- **Enable gating:** en toggled 1/0 every cycle from 0 → out advances only on enabled edges: 0,1,1,2,2,3; tc never asserts while en=0.
